// File: rtl/regex_cpu_pipelined.sv
// Pipelined regex execution core.
// A thread is captured into FETCH, its instruction is requested from the shared
// instruction memory, and it is executed in EXEC against the character window.
// Successor threads are queued in a small output FIFO. ACCEPT-type opcodes pulse
// accepts instead of producing successors.
module regex_cpu_pipelined #(
   parameter int PC_WIDTH              = 9,
   parameter int CHARACTER_WIDTH       = 8,
   parameter int MEMORY_WIDTH          = 16,
   parameter int MEMORY_ADDR_WIDTH     = 11,
   parameter int FIFO_WIDTH_POWER_OF_2 = 2,
   parameter int CC_ID_BITS            = 2
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [(1<<CC_ID_BITS)*CHARACTER_WIDTH-1:0]        current_characters,
   input  logic [(1<<CC_ID_BITS)-1:0]                        end_of_string,
   input  logic                                              input_pc_valid,
   input  logic [CC_ID_BITS-1:0]                             input_cc_id,
   input  logic [PC_WIDTH-1:0]                               input_pc,
   output logic                                              input_pc_ready,
   output logic                                              memory_valid,
   output logic [MEMORY_ADDR_WIDTH-1:0]                      memory_addr,
   input  logic                                              memory_ready,
   input  logic [MEMORY_WIDTH-1:0]                           memory_data,
   output logic                                              output_pc_valid,
   output logic [CC_ID_BITS-1:0]                             output_cc_id,
   output logic [PC_WIDTH-1:0]                               output_pc,
   input  logic                                              output_pc_ready,
   output logic                                              accepts,
   output logic [(1<<CC_ID_BITS)-1:0]                        elaborating_chars,
   output logic                                              running
);

   localparam int PW    = PC_WIDTH;
   localparam int CW    = CHARACTER_WIDTH;
   localparam int MW    = MEMORY_WIDTH;
   localparam int FW    = FIFO_WIDTH_POWER_OF_2;
   localparam int CB    = CC_ID_BITS;
   localparam int DEPTH = 1 << FW;
   localparam int CCN   = 1 << CB;

   // Opcodes live in the top three bits of the instruction word.
   localparam logic [2:0] OP_ACCEPT         = 3'b000;
   localparam logic [2:0] OP_SPLIT          = 3'b001;
   localparam logic [2:0] OP_MATCH          = 3'b010;
   localparam logic [2:0] OP_JMP            = 3'b011;
   localparam logic [2:0] OP_END            = 3'b100;
   localparam logic [2:0] OP_MATCH_ANY      = 3'b101;
   localparam logic [2:0] OP_ACCEPT_PARTIAL = 3'b110;
   localparam logic [2:0] OP_NOT_MATCH      = 3'b111;

   // Stage and FIFO state
   logic              ready_en;
   logic              fetch_valid;
   logic [PW-1:0]     fetch_pc;
   logic [CB-1:0]     fetch_cc;
   logic              exec_valid;
   logic              exec_first;
   logic [PW-1:0]     exec_pc;
   logic [CB-1:0]     exec_cc;
   logic [MW-1:0]     instr_reg;
   logic              accept_reg;
   logic [FW-1:0]     wr_ptr;
   logic [FW-1:0]     rd_ptr;
   logic [FW:0]       count;
   logic [PW-1:0]     fifo_pc [DEPTH];
   logic [CB-1:0]     fifo_cc [DEPTH];
   logic [DEPTH-1:0]  entry_valid;

   // Execute-side combinational signals
   logic [MW-1:0]     instr;
   logic [2:0]        opcode;
   logic [CW-1:0]     ch;
   logic              eos;
   logic [PW-1:0]     pc_inc;
   logic [CB-1:0]     cc_inc;
   logic [PW-1:0]     jump_pc;
   logic [1:0]        need_cnt;
   logic [1:0]        push_cnt;
   logic [PW-1:0]     e0_pc;
   logic [CB-1:0]     e0_cc;
   logic [PW-1:0]     e1_pc;
   logic [CB-1:0]     e1_cc;
   logic              accept_hit;
   logic              pop;
   logic [FW+1:0]     room;
   logic              exec_fire;
   logic              exec_free;
   logic              hs;
   logic              take;
   logic              unused_bits;

   // The instruction is only on memory_data for one cycle; afterwards use the latched copy.
   assign instr   = exec_first ? memory_data : instr_reg;
   assign opcode  = instr[MW-1 -: 3];
   assign ch      = current_characters[exec_cc*CW +: CW];
   assign eos     = end_of_string[exec_cc];
   assign pc_inc  = exec_pc + 1'b1;
   assign cc_inc  = exec_cc + 1'b1;
   assign jump_pc = instr[PW-1:0];

   generate
      if (MW - 4 >= PW) begin : g_unused
         assign unused_bits = ^instr[MW-4:PW];
      end else begin : g_no_unused
         assign unused_bits = 1'b0;
      end
   endgenerate

   // Decode the opcode into successor threads and an accept request.
   always_comb begin
      need_cnt   = 2'd0;
      e0_pc      = pc_inc;
      e0_cc      = exec_cc;
      e1_pc      = jump_pc;
      e1_cc      = exec_cc;
      accept_hit = 1'b0;
      case (opcode)
         OP_ACCEPT:         accept_hit = eos;
         OP_SPLIT:          need_cnt = 2'd2;
         OP_MATCH: begin
            if (!eos && ch == instr[CW-1:0]) begin
               need_cnt = 2'd1;
               e0_cc    = cc_inc;
            end
         end
         OP_JMP: begin
            need_cnt = 2'd1;
            e0_pc    = jump_pc;
         end
         OP_END:            need_cnt = 2'd0;
         OP_MATCH_ANY: begin
            if (!eos) begin
               need_cnt = 2'd1;
               e0_cc    = cc_inc;
            end
         end
         OP_ACCEPT_PARTIAL: accept_hit = 1'b1;
         OP_NOT_MATCH: begin
            if (!eos && ch != instr[CW-1:0]) begin
               need_cnt = 2'd1;
               e0_cc    = cc_inc;
            end
         end
         default:           need_cnt = 2'd0;
      endcase
   end

   // EXEC retires only when every successor fits, counting a same-cycle pop as free space.
   assign output_pc_valid = (count != '0);
   assign pop       = output_pc_valid && output_pc_ready;
   assign room      = (FW+2)'(DEPTH) - (FW+2)'(count) + (FW+2)'(pop);
   assign exec_fire = exec_valid && ((FW+2)'(need_cnt) <= room);
   assign push_cnt  = exec_fire ? need_cnt : 2'd0;
   assign exec_free = !exec_valid || exec_fire;

   // FETCH only requests while EXEC can take the fetched thread, so the request never retracts.
   assign memory_valid   = fetch_valid && exec_free;
   assign memory_addr    = {{(MEMORY_ADDR_WIDTH-PW){1'b0}}, fetch_pc};
   assign hs             = memory_valid && memory_ready;
   assign input_pc_ready = ready_en && (!fetch_valid || hs);
   assign take           = input_pc_valid && input_pc_ready;
   assign accepts        = accept_reg;

   assign output_pc    = output_pc_valid ? fifo_pc[rd_ptr] : '0;
   assign output_cc_id = output_pc_valid ? fifo_cc[rd_ptr] : '0;

   // Holds input_pc_ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ready_en <= 1'b0;
      else      ready_en <= 1'b1;
   end

   // FETCH stage: capture a thread, release it on the memory handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_valid <= 1'b0;
         fetch_pc    <= '0;
         fetch_cc    <= '0;
      end else if (take) begin
         fetch_valid <= 1'b1;
         fetch_pc    <= input_pc;
         fetch_cc    <= input_cc_id;
      end else if (hs) begin
         fetch_valid <= 1'b0;
      end
   end

   // EXEC stage: load on handshake, latch the instruction while stalled, clear on retire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exec_valid <= 1'b0;
         exec_first <= 1'b0;
         exec_pc    <= '0;
         exec_cc    <= '0;
         instr_reg  <= '0;
         accept_reg <= 1'b0;
      end else begin
         accept_reg <= exec_fire && accept_hit;
         if (exec_valid) instr_reg <= instr;
         if (hs) begin
            exec_valid <= 1'b1;
            exec_first <= 1'b1;
            exec_pc    <= fetch_pc;
            exec_cc    <= fetch_cc;
         end else if (exec_fire) begin
            exec_valid <= 1'b0;
            exec_first <= 1'b0;
         end else begin
            exec_first <= 1'b0;
         end
      end
   end

   // FIFO pointers and occupancy; up to two pushes and one pop per cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + FW'(push_cnt);
         rd_ptr <= rd_ptr + FW'(pop);
         count  <= count + (FW+1)'(push_cnt) - (FW+1)'(pop);
      end
   end

   // FIFO storage: first successor at wr_ptr, second at wr_ptr+1.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push_cnt != 2'd0 && wr_ptr == FW'(i)) begin
            fifo_pc[i] <= e0_pc;
            fifo_cc[i] <= e0_cc;
         end else if (push_cnt == 2'd2 && FW'(wr_ptr + 1'b1) == FW'(i)) begin
            fifo_pc[i] <= e1_pc;
            fifo_cc[i] <= e1_cc;
         end
      end
   end

   // An entry is live when its distance from the read pointer is below the count.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [FW-1:0] ofs;
         assign ofs             = FW'(gi) - rd_ptr;
         assign entry_valid[gi] = ({1'b0, ofs} < count);
      end
   endgenerate

   // Mark every window slot that still has a thread in FETCH, EXEC or the FIFO.
   always_comb begin
      elaborating_chars = '0;
      if (fetch_valid) elaborating_chars[fetch_cc] = 1'b1;
      if (exec_valid)  elaborating_chars[exec_cc]  = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) elaborating_chars[fifo_cc[i]] = 1'b1;
      end
   end

   assign running = |elaborating_chars;

endmodule

// File: tb/tb_regex_cpu_pipelined.sv
// Self-checking bench for regex_cpu_pipelined: table of single-thread vectors,
// a streamed JMP sweep and hand-written sequences for handshake, backpressure and reset.
module tb_regex_cpu_pipelined;

   logic         clk;
   logic         rst;
   logic [31:0]  current_characters;
   logic [3:0]   end_of_string;
   logic         input_pc_valid;
   logic [1:0]   input_cc_id;
   logic [8:0]   input_pc;
   logic         input_pc_ready;
   logic         memory_valid;
   logic [10:0]  memory_addr;
   logic         memory_ready;
   logic [15:0]  memory_data;
   logic         output_pc_valid;
   logic [1:0]   output_cc_id;
   logic [8:0]   output_pc;
   logic         output_pc_ready;
   logic         accepts;
   logic [3:0]   elaborating_chars;
   logic         running;

   regex_cpu_pipelined dut (
      .clk                (clk),
      .rst                (rst),
      .current_characters (current_characters),
      .end_of_string      (end_of_string),
      .input_pc_valid     (input_pc_valid),
      .input_cc_id        (input_cc_id),
      .input_pc           (input_pc),
      .input_pc_ready     (input_pc_ready),
      .memory_valid       (memory_valid),
      .memory_addr        (memory_addr),
      .memory_ready       (memory_ready),
      .memory_data        (memory_data),
      .output_pc_valid    (output_pc_valid),
      .output_cc_id       (output_cc_id),
      .output_pc          (output_pc),
      .output_pc_ready    (output_pc_ready),
      .accepts            (accepts),
      .elaborating_chars  (elaborating_chars),
      .running            (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0] pc;
      logic [1:0] cc;
   } thr_t;

   typedef struct {
      logic [2:0]  op;
      logic [12:0] d;
      logic [8:0]  pc;
      logic [1:0]  cc;
      logic [7:0]  ch;
      logic        eos;
      int          n_out;
      logic [8:0]  p0;
      logic [1:0]  c0;
      logic [8:0]  p1;
      logic [1:0]  c1;
      int          n_acc;
   } vec_t;

   logic [15:0] prog [0:511];
   thr_t        sb_q[$];
   logic [10:0] fetch_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          acc_seen = 0;
   logic        auto_mem = 1'b1;
   logic        mem_hs;
   logic [10:0] mem_a;
   vec_t        vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: timed out, expected completion", name);
   endtask

   // Instruction memory model: answers a handshake with prog[addr] one cycle later.
   initial begin
      memory_ready = 1'b1;
      memory_data  = '0;
      forever begin
         @(negedge clk);
         mem_hs = memory_valid && memory_ready && rst;
         mem_a  = memory_addr;
         @(posedge clk);
         #1;
         memory_data = mem_hs ? prog[mem_a[8:0]] : 16'($urandom);
         if (auto_mem) memory_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Output / fetch-address scoreboard and accept counter.
   initial begin
      thr_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (output_pc_valid && output_pc_ready) begin
               if (sb_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("[TB] FAIL spurious_output: got pc=%0d cc=%0d, expected none", output_pc, output_cc_id);
               end else begin
                  e = sb_q.pop_front();
                  check("out_pc", 32'(output_pc), 32'(e.pc));
                  check("out_cc", 32'(output_cc_id), 32'(e.cc));
                  $display("[TB] pop pc=%0d cc=%0d", output_pc, output_cc_id);
               end
            end
            if (memory_valid && memory_ready) begin
               if (fetch_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("[TB] FAIL spurious_fetch: got addr=%0d, expected none", memory_addr);
               end else begin
                  check("mem_addr", 32'(memory_addr), 32'(fetch_q.pop_front()));
               end
            end
            if (accepts) acc_seen++;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic send_thread(input logic [8:0] pc, input logic [1:0] cc);
      bit got;
      @(posedge clk);
      #1;
      input_pc_valid = 1'b1;
      input_pc       = pc;
      input_cc_id    = cc;
      got = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (input_pc_ready) begin
            got = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      input_pc_valid = 1'b0;
      if (got) fetch_q.push_back({2'b00, pc});
      else     timeout_fail("input_handshake");
      $display("[TB] send pc=%0d cc=%0d", pc, cc);
   endtask

   task automatic wait_idle(input string name);
      bit idle;
      idle = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!running) begin
            idle = 1;
            break;
         end
      end
      if (!idle) timeout_fail(name);
      repeat (3) @(negedge clk);
   endtask

   task automatic apply_vec(input int i);
      vec_t v;
      int   acc0;
      logic [31:0] chars;
      logic [3:0]  eosv;
      v = vecs[i];
      prog[v.pc] = {v.op, v.d};
      chars = $urandom;
      chars[v.cc*8 +: 8] = v.ch;
      eosv = 4'($urandom);
      eosv[v.cc] = v.eos;
      current_characters = chars;
      end_of_string      = eosv;
      if (v.n_out >= 1) sb_q.push_back({v.p0, v.c0});
      if (v.n_out >= 2) sb_q.push_back({v.p1, v.c1});
      acc0 = acc_seen;
      send_thread(v.pc, v.cc);
      wait_idle($sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_accepts", i), 32'(acc_seen - acc0), 32'(v.n_acc));
      check($sformatf("vec%0d_sb_empty", i), 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      logic [8:0] d;
      vecs[0]  = '{3'b010, 13'h0061, 9'd10,  2'd1, 8'h61, 1'b0, 1, 9'd11,  2'd2, 9'd0, 2'd0, 0};
      vecs[1]  = '{3'b010, 13'h0062, 9'd10,  2'd1, 8'h61, 1'b0, 0, 9'd0,   2'd0, 9'd0, 2'd0, 0};
      vecs[2]  = '{3'b001, 13'd40,   9'd7,   2'd3, 8'h00, 1'b0, 2, 9'd8,   2'd3, 9'd40, 2'd3, 0};
      vecs[3]  = '{3'b000, 13'd0,    9'd20,  2'd2, 8'h00, 1'b1, 0, 9'd0,   2'd0, 9'd0, 2'd0, 1};
      vecs[4]  = '{3'b000, 13'd0,    9'd20,  2'd2, 8'h00, 1'b0, 0, 9'd0,   2'd0, 9'd0, 2'd0, 0};
      vecs[5]  = '{3'b101, 13'd0,    9'd511, 2'd3, 8'h33, 1'b0, 1, 9'd0,   2'd0, 9'd0, 2'd0, 0};
      vecs[6]  = '{3'b101, 13'd0,    9'd33,  2'd1, 8'h33, 1'b1, 0, 9'd0,   2'd0, 9'd0, 2'd0, 0};
      vecs[7]  = '{3'b110, 13'd0,    9'd30,  2'd0, 8'h00, 1'b0, 0, 9'd0,   2'd0, 9'd0, 2'd0, 1};
      vecs[8]  = '{3'b111, 13'h0042, 9'd50,  2'd0, 8'h41, 1'b0, 1, 9'd51,  2'd1, 9'd0, 2'd0, 0};
      vecs[9]  = '{3'b111, 13'h0041, 9'd50,  2'd0, 8'h41, 1'b0, 0, 9'd0,   2'd0, 9'd0, 2'd0, 0};
      vecs[10] = '{3'b100, 13'h1abc, 9'd60,  2'd2, 8'h00, 1'b0, 0, 9'd0,   2'd0, 9'd0, 2'd0, 0};
      vecs[11] = '{3'b011, 13'h1fff, 9'd100, 2'd2, 8'h00, 1'b0, 1, 9'd511, 2'd2, 9'd0, 2'd0, 0};
      vecs[12] = '{3'b010, 13'h0061, 9'd12,  2'd1, 8'h61, 1'b1, 0, 9'd0,   2'd0, 9'd0, 2'd0, 0};
      vecs[13] = '{3'b010, 13'h1561, 9'd13,  2'd3, 8'h61, 1'b0, 1, 9'd14,  2'd0, 9'd0, 2'd0, 0};
      vecs[14] = '{3'b001, 13'd5,    9'd511, 2'd0, 8'h00, 1'b0, 2, 9'd0,   2'd0, 9'd5, 2'd0, 0};
      vecs[15] = '{3'b111, 13'h0042, 9'd51,  2'd2, 8'h41, 1'b1, 0, 9'd0,   2'd0, 9'd0, 2'd0, 0};
      vecs[16] = '{3'b110, 13'd0,    9'd31,  2'd1, 8'h00, 1'b1, 0, 9'd0,   2'd0, 9'd0, 2'd0, 1};

      for (int i = 0; i < 512; i++) prog[i] = 16'h8000;
      rst = 1'b0;
      input_pc_valid = 1'b0;
      input_pc = '0;
      input_cc_id = '0;
      output_pc_ready = 1'b1;
      current_characters = '0;
      end_of_string = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(output_pc_valid), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_elab", 32'(elaborating_chars), 32'd0);
      check("rst_accepts", 32'(accepts), 32'd0);
      check("rst_mem_valid", 32'(memory_valid), 32'd0);
      check("rst_in_ready", 32'(input_pc_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_in_ready", 32'(input_pc_ready), 32'd1);

      // Table-driven single-thread vectors
      for (int i = 0; i < 17; i++) apply_vec(i);

      // Streamed JMP sweep
      for (int pc = 245; pc <= 311; pc++) begin
         d = 9'(220 + ((pc - 245) * 3) % 90);
         prog[pc] = {3'b011, 4'b0000, d};
         sb_q.push_back({d, 2'(pc % 4)});
         send_thread(9'(pc), 2'(pc % 4));
      end
      wait_idle("sweep_idle");
      check("sweep_sb_empty", 32'(sb_q.size()), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("sweep_quiet_running", 32'(running), 32'd0);
         check("sweep_quiet_valid", 32'(output_pc_valid), 32'd0);
      end

      // Fetch handshake held off for 5 cycles
      @(negedge clk);
      auto_mem = 1'b0;
      memory_ready = 1'b0;
      prog[77] = {3'b011, 13'd123};
      sb_q.push_back({9'd123, 2'd0});
      send_thread(9'd77, 2'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_mem_valid", 32'(memory_valid), 32'd1);
         check("hold_mem_addr", 32'(memory_addr), 32'd77);
      end
      @(posedge clk);
      #1;
      memory_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      memory_ready = 1'b0;
      @(negedge clk);
      check("mem_valid_drop", 32'(memory_valid), 32'd0);
      auto_mem = 1'b1;
      wait_idle("hs_idle");
      check("hs_sb_empty", 32'(sb_q.size()), 32'd0);

      // Backpressure: FIFO full, EXEC stalled, FETCH blocked
      @(posedge clk);
      #1;
      output_pc_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         prog[200 + i] = {3'b011, 13'(300 + i)};
         sb_q.push_back({9'(300 + i), (i == 5) ? 2'd3 : 2'd1});
         send_thread(9'(200 + i), (i == 5) ? 2'd3 : 2'd1);
      end
      repeat (10) @(negedge clk);
      check("bp_in_ready", 32'(input_pc_ready), 32'd0);
      check("bp_mem_valid", 32'(memory_valid), 32'd0);
      check("bp_elab", 32'(elaborating_chars), 32'b1010);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_head_valid", 32'(output_pc_valid), 32'd1);
         check("bp_head_pc", 32'(output_pc), 32'd300);
      end
      @(posedge clk);
      #1;
      output_pc_ready = 1'b1;
      wait_idle("bp_idle");
      check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

      // Reset in the middle of operation discards everything
      @(posedge clk);
      #1;
      output_pc_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         prog[210 + i] = {3'b011, 13'(400 + i)};
         sb_q.push_back({9'(400 + i), 2'(i)});
         send_thread(9'(210 + i), 2'(i));
      end
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 32'(output_pc_valid), 32'd0);
      check("midrst_running", 32'(running), 32'd0);
      sb_q.delete();
      fetch_q.delete();
      @(negedge clk);
      check("midrst_elab", 32'(elaborating_chars), 32'd0);
      check("midrst_mem_valid", 32'(memory_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      output_pc_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("midrst_quiet", 32'(running), 32'd0);
      apply_vec(0);
      apply_vec(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
